// File: rtl/compress_sched.sv
// compress_sched: round-robin scheduler sharing one block-compression datapath
// among NUM_REQ requesters, with a completion timeout and valid/ready result port.
module compress_sched #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*1024-1:0] req_pixels,
    output logic [1023:0]           dp_pixels,
    output logic                    dp_start,
    input  logic                    dp_done,
    input  logic [31:0]             dp_min,
    input  logic [31:0]             dp_max,
    input  logic                    dp_compressable,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [31:0]             res_min,
    output logic [31:0]             res_max,
    output logic                    res_compressable,
    output logic                    res_timeout,
    output logic                    busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [CW-1:0] cnt;
    logic found;
    int idx;
    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                grant = ID_W'(idx);
                found = 1'b1;
            end
        end
    end
    assign req_ready = (state == IDLE && found && !rst) ? NUM_REQ'(1) << grant : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            cnt <= '0;
            dp_pixels <= '0;
            dp_start <= 1'b0;
            res_valid <= 1'b0;
            res_id <= '0;
            res_min <= '0;
            res_max <= '0;
            res_compressable <= 1'b0;
            res_timeout <= 1'b0;
            busy <= 1'b0;
        end else begin
            dp_start <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    dp_pixels <= req_pixels[grant*1024 +: 1024];
                    res_id <= grant;
                    rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    dp_start <= 1'b1;
                    busy <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    cnt <= '0;
                    state <= WAIT;
                end
                WAIT: if (dp_done) begin
                    res_min <= dp_min;
                    res_max <= dp_max;
                    res_compressable <= dp_compressable;
                    res_timeout <= 1'b0;
                    res_valid <= 1'b1;
                    state <= RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    res_min <= '0;
                    res_max <= '0;
                    res_compressable <= 1'b0;
                    res_timeout <= 1'b1;
                    res_valid <= 1'b1;
                    state <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_compress_sched.sv
// tb_compress_sched: directed checks of arbitration, timing, timeout, stall and reset.
module tb_compress_sched;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;
    localparam int ID_W = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_REQ-1:0] req_valid = '0;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ*1024-1:0] req_pixels = '0;
    logic [1023:0] dp_pixels;
    logic dp_start;
    logic dp_done = 1'b0;
    logic [31:0] dp_min = '0;
    logic [31:0] dp_max = '0;
    logic dp_compressable = 1'b0;
    logic res_valid;
    logic res_ready = 1'b1;
    logic [ID_W-1:0] res_id;
    logic [31:0] res_min;
    logic [31:0] res_max;
    logic res_compressable;
    logic res_timeout;
    logic busy;
    int n_cmp = 0;
    int n_bad = 0;
    logic [1023:0] exp_blk;

    compress_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_pixels(req_pixels), .dp_pixels(dp_pixels), .dp_start(dp_start),
        .dp_done(dp_done), .dp_min(dp_min), .dp_max(dp_max),
        .dp_compressable(dp_compressable), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_min(res_min), .res_max(res_max),
        .res_compressable(res_compressable), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NUM_REQ; k++)
            for (int i = 0; i < 32; i++)
                for (int j = 0; j < 4; j++)
                    req_pixels[k*1024 + (i*4+j)*8 +: 8] = (k == 2) ? 8'(i + j) : 8'(8'h80 ^ (k*16) ^ (i*4 + j));
        repeat (2) step();
        n_cmp++; if (dp_pixels !== '0) begin n_bad++; $display("FAIL reset_dp_pixels got %h want 0", dp_pixels[31:0]); end
        n_cmp++; if ({dp_start, res_valid, res_compressable, res_timeout, busy} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got %b want 00000", {dp_start, res_valid, res_compressable, res_timeout, busy}); end
        n_cmp++; if ({res_id, res_min, res_max} !== '0) begin n_bad++; $display("FAIL reset_res got %h %h %h want 0", res_id, res_min, res_max); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 4; j++)
                exp_blk[(i*4+j)*8 +: 8] = 8'(i + j);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_grant got %b want 0100", req_ready); end
        step();
        req_valid = 4'b0000;
        n_cmp++; if (dp_start !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL single_start got start=%b busy=%b want 1 1", dp_start, busy); end
        n_cmp++; if (dp_pixels !== exp_blk) begin n_bad++; $display("FAIL single_pixels got %h want %h", dp_pixels[63:0], exp_blk[63:0]); end
        n_cmp++; if (res_id !== 2'd2) begin n_bad++; $display("FAIL single_id_latch got %0d want 2", res_id); end
        step();
        n_cmp++; if (dp_start !== 1'b0) begin n_bad++; $display("FAIL single_start_pulse got %b want 0", dp_start); end
        step();
        dp_done = 1'b1; dp_min = 32'h00010203; dp_max = 32'h1F202122; dp_compressable = 1'b1;
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got %b want 0", res_valid); end
        step();
        dp_done = 1'b0; dp_min = '0; dp_max = '0; dp_compressable = 1'b0;
        n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_timeout !== 1'b0) begin n_bad++; $display("FAIL single_result got v=%b id=%0d to=%b want 1 2 0", res_valid, res_id, res_timeout); end
        n_cmp++; if (res_min !== 32'h00010203 || res_max !== 32'h1F202122 || res_compressable !== 1'b1) begin n_bad++; $display("FAIL single_values got %h %h %b want 00010203 1f202122 1", res_min, res_max, res_compressable); end
        step();
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_release got v=%b busy=%b want 0 0", res_valid, busy); end
    endtask

    task automatic test_timeout();
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        for (int k = 1; k < TIMEOUT + 2; k++) begin
            n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_early cycle %0d got %b want 0", k, res_valid); end
            step();
        end
        n_cmp++; if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_id !== 2'd0) begin n_bad++; $display("FAIL timeout_result got v=%b to=%b id=%0d want 1 1 0", res_valid, res_timeout, res_id); end
        n_cmp++; if (res_min !== '0 || res_max !== '0 || res_compressable !== 1'b0) begin n_bad++; $display("FAIL timeout_values got %h %h %b want 0 0 0", res_min, res_max, res_compressable); end
        step();
    endtask

    task automatic test_stall();
        res_ready = 1'b0;
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0000;
        step();
        dp_done = 1'b1; dp_min = 32'h0A0B0C0D; dp_max = 32'hF0E0D0C0; dp_compressable = 1'b0;
        step();
        dp_done = 1'b0; dp_min = '0; dp_max = '0;
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_timeout !== 1'b0 || res_compressable !== 1'b0) begin n_bad++; $display("FAIL stall_flags c%0d got v=%b id=%0d to=%b cmp=%b want 1 3 0 0", c, res_valid, res_id, res_timeout, res_compressable); end
            n_cmp++; if (res_min !== 32'h0A0B0C0D || res_max !== 32'hF0E0D0C0) begin n_bad++; $display("FAIL stall_values c%0d got %h %h want 0a0b0c0d f0e0d0c0", c, res_min, res_max); end
            n_cmp++; if (req_ready !== 4'b0000 || dp_start !== 1'b0) begin n_bad++; $display("FAIL stall_quiet c%0d got ready=%b start=%b want 0000 0", c, req_ready, dp_start); end
            step();
        end
        res_ready = 1'b1;
        req_valid = 4'b0000;
        step();
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stall_release got v=%b busy=%b want 0 0", res_valid, busy); end
    endtask

    task automatic test_stray_done();
        dp_done = 1'b1; dp_min = 32'hAAAAAAAA;
        step();
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stray_idle got v=%b busy=%b want 0 0", res_valid, busy); end
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        step();
        dp_done = 1'b0;
        step();
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL stray_issue got v=%b busy=%b want 0 1", res_valid, busy); end
        dp_done = 1'b1; dp_min = 32'h11223344; dp_max = 32'h55667788; dp_compressable = 1'b1;
        step();
        dp_done = 1'b0;
        n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_min !== 32'h11223344 || res_max !== 32'h55667788) begin n_bad++; $display("FAIL stray_result got v=%b id=%0d %h %h want 1 1 11223344 55667788", res_valid, res_id, res_min, res_max); end
        step();
    endtask

    task automatic test_rst_wait();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({dp_start, res_valid, res_timeout, busy} !== 4'b0 || dp_pixels !== '0 || res_id !== '0) begin n_bad++; $display("FAIL rst_async got start=%b v=%b to=%b busy=%b id=%0d want all 0", dp_start, res_valid, res_timeout, busy, res_id); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
        step();
        rst = 1'b0;
        dp_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_no_result c%0d got v=%b busy=%b want 0 0", c, res_valid, busy); end
        end
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_rr_restart got %b want 0001", req_ready); end
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 6; g++) begin
            #1;
            n_cmp++; if (req_ready !== 4'(1 << (g % 4))) begin n_bad++; $display("FAIL b2b_grant %0d got %b want %b", g, req_ready, 4'(1 << (g % 4))); end
            step();
            exp_blk = req_pixels[(g % 4)*1024 +: 1024];
            n_cmp++; if (dp_pixels !== exp_blk || dp_start !== 1'b1) begin n_bad++; $display("FAIL b2b_issue %0d got start=%b px=%h want 1 %h", g, dp_start, dp_pixels[31:0], exp_blk[31:0]); end
            repeat (2) step();
            n_cmp++; if (res_valid !== 1'b1 || res_id !== ID_W'(g % 4)) begin n_bad++; $display("FAIL b2b_result %0d got v=%b id=%0d want 1 %0d", g, res_valid, res_id, g % 4); end
            step();
        end
        req_valid = 4'b0000;
        dp_done = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_stall();
        test_stray_done();
        test_rst_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/compress_sched.md
# compress_sched

Round-robin scheduler that shares the single pixel-block compression datapath (min/max header + residual compressibility check) among `NUM_REQ` block sources. It accepts one 32-pixel RGBA block at a time from a requester, drives it to the datapath with a start pulse, and waits for completion under a timeout. It then returns the header min/max values and the compressible flag, tagged with the requester ID, over a valid/ready result port. It sits between the tile fetch front-ends and the `cpu` compression datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2
- `TIMEOUT`, 16: max WAIT cycles before abort, ≥1
- `ID_W`, $clog2(NUM_REQ): result ID width (derived)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester block offered
- `req_ready`  out  NUM_REQ  one-hot grant/accept, combinational in IDLE
- `req_pixels`  in  NUM_REQ*1024  requester k at bits [k*1024 +: 1024]; pixel i channel j (0=r,1=g,2=b,3=a) at [(i*4+j)*8 +: 8]
- `dp_pixels`  out  1024  block driven to the datapath
- `dp_start`  out  1  one-cycle start pulse
- `dp_done`  in  1  datapath completion pulse
- `dp_min`  in  32  {r_min,g_min,b_min,a_min}, r in [31:24]
- `dp_max`  in  32  {r_max,g_max,b_max,a_max}
- `dp_compressable`  in  1  residual compressible flag
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_id`  out  ID_W  index of the requester served
- `res_min`, `res_max`  out  32 each  captured header values
- `res_compressable`  out  1  captured flag
- `res_timeout`  out  1  datapath did not finish in time
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = first k with `req_valid[k]`=1, searched from `rr_ptr` upward, wrapping mod NUM_REQ. `req_ready` = one-hot(grant), all zero if no valid. On handshake: latch `req_pixels[grant]` into `dp_pixels`, grant into `res_id`, set `rr_ptr` = (grant+1) mod NUM_REQ, go to ISSUE.
- `req_ready` is zero in every state except IDLE.
- ISSUE: `dp_start`=1 for exactly this cycle; clear the wait counter; go to WAIT.
- WAIT: if `dp_done`=1, capture `dp_min`, `dp_max` and `dp_compressable`, set `res_timeout`=0 and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to RESP with `res_min`=`res_max`=0, `res_compressable`=0 and `res_timeout`=1.
- RESP: `res_valid`=1. All `res_*` outputs stay stable until `res_ready`=1, then go to IDLE.
- `dp_done` is ignored in IDLE, ISSUE and RESP.
- `dp_pixels` is held from the latch until the next acceptance.
- Reset: state IDLE, `rr_ptr`=0, counter 0. Every output is 0: `dp_pixels`, `dp_start`, `res_*`, `busy`, and `req_ready` (no requester is valid while in reset).
- Reset mid-operation drops the block in flight. No result is produced for it.

## Timing
- Acceptance at cycle t. Then `dp_start` high during t+1, and WAIT begins at t+2.
- `dp_done` is first honoured at t+2. Done at t+2 gives `res_valid` at t+3.
- If `res_ready`=1 at t+3, state returns to IDLE at t+4, where the next acceptance can occur. Minimum period is 4 cycles per block.
- Timeout: with no done, the counter reaches TIMEOUT in the WAIT cycle t+1+TIMEOUT, and `res_valid` rises at t+2+TIMEOUT.
- `dp_done` arriving in the same cycle the counter would reach TIMEOUT counts as success (done has priority).
- A requester that keeps `req_valid` high through RESP is not accepted until IDLE.

## Test plan
- Single block from req 2, pixel k channel j = k+j. `dp_start` at t+1, model `dp_done` at t+3 with min 0x00010203, max 0x1F202122, compressable=1 → `res_valid` at t+4 with id=2, the same min/max, compressable=1, timeout=0.
- All 4 requesters valid continuously, datapath done at the first WAIT cycle, `res_ready` tied 1 → grants 0,1,2,3,0,1 at a 4-cycle spacing.
- `dp_done` never asserted, TIMEOUT=16 → `res_valid` exactly 18 cycles after acceptance, timeout=1, min/max=0, compressable=0.
- `res_ready` held low 5 cycles in RESP → `res_valid` and all `res_*` outputs stable, `req_ready` all 0, no new `dp_start`.
- `rst` pulsed during WAIT → all outputs 0 asynchronously, no result appears, and the next grant starts from requester 0.
- Stray `dp_done` during IDLE and ISSUE → ignored. `res_valid` follows only the done seen in WAIT.
